nibble_serial_add_ctrl: RTL
===========================

# nibble_serial_add_ctrl

Sequencing controller that performs WIDTH-bit add/subtract by driving a single 4-bit carry-lookahead slice one nibble per cycle. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It owns the carry chain, the nibble index and the result register, so wide arithmetic is built from one shared 4-bit datapath.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  controller can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A−B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, latch A, B^{WIDTH{in_sub}} and sub, set carry=in_sub and k=0, then go to RUN.
  - RUN: one nibble per cycle. Slice inputs are A[4k+3:4k], B'[4k+3:4k] and the carry register. The slice sum is written to result[4k+3:4k]. The carry register takes slice c4. k increments. On k==NIB−1 (NIB=WIDTH/4), also capture out_cout=c4 and out_ovf=c4^c3 from the final slice, then go to DONE.
  - DONE: out_valid=1. Hold out_sum/out_cout/out_ovf stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and no operand is queued.
- Nibble index k is log2(NIB) bits wide (minimum 1). For NIB=1, RUN lasts exactly one cycle.
- Arithmetic is modulo 2^WIDTH. Subtract uses one's complement of B plus carry-in 1.
- Reset mid-operation: abort immediately to IDLE. Any in-flight result is discarded and never presented.

## Timing
- Reset values: in_ready=1 (in IDLE after reset release); out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, internal carry=0, k=0.
- Latency: if the input handshake occurs on edge T, out_valid rises after edge T+NIB. For WIDTH=16 this is 4 cycles.
- Throughput: one operation per NIB+2 cycles at best. This includes the DONE handshake cycle and the return to IDLE.
- Outputs are registered; no combinational path exists from in_* to out_*.
- Output handshake rule: out_valid stays high and out_sum is unchanged until out_ready is sampled high. out_ready while out_valid=0 has no effect.
- in_ready is a pure function of state. It goes low on the cycle after acceptance.

## Structure
- Shared package contains:
  - state enum {IDLE, RUN, DONE};
  - the nibble-width constant 4;
  - a NIB=WIDTH/4 helper function;
  - the k-width helper.
- One sub-module, cla4: a combinational 4-bit carry-lookahead slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], c3 (carry into bit 3), c4.
  - Implementation: generate g=a&b, propagate p=a^b, sum=p^c[3:0].
- The controller instantiates exactly one cla4. The slice operand mux (nibble select by k) is in the controller.

## Test plan
- Add, WIDTH=16: 0x1234+0x0FCD, sub=0 → after 4 cycles out_sum=0x2201, cout=0, ovf=0.
- Signed overflow: 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1. Unsigned wrap: 0xFFFF+0x0001 → 0x0000, cout=1, ovf=0.
- Subtract:
  - 0x0005−0x0007 → 0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → out_valid and out_sum stay stable. in_valid pulsed during RUN/DONE is not accepted (in_ready=0). After out_ready=1, the next operand is accepted from IDLE.
- Reset mid-RUN: assert rst low at k=2 → on the same edge all outputs return to reset values. After release, out_valid is never asserted for the aborted operation.
- Parameter sweep WIDTH=4 and WIDTH=32 with random operands against a reference model. Latency is 1 and 8 cycles respectively, with exact sum, cout and ovf.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared state type and nibble sizing helpers
package nibble_serial_add_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NIBBLE = 4;
   function automatic int nib_count(int width);
      return width / NIBBLE;
   endfunction
   function automatic int k_width(int width);
      return nib_count(width) > 1 ? $clog2(nib_count(width)) : 1;
   endfunction
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand and result handshake bundle
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
   logic             in_valid, in_ready, in_sub;
   logic [WIDTH-1:0] in_a, in_b;
   logic             out_valid, out_ready, out_cout, out_ovf;
   logic [WIDTH-1:0] out_sum;
   modport master (output in_valid, in_a, in_b, in_sub, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout, out_ovf);
   modport slave  (input  in_valid, in_a, in_b, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_cout, out_ovf);
endinterface

// File: rtl/nibble_serial_add_ctrl_cla4.sv
// nibble_serial_add_ctrl_cla4: combinational 4-bit carry-lookahead slice
module nibble_serial_add_ctrl_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       c3,
   output logic       c4
);
   logic [3:0] g, p, c;
   assign g = a & b;
   assign p = a ^ b;
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
   assign c3  = c[3];
   assign sum = p ^ c;
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide add/subtract sequenced through one 4-bit CLA slice
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   nibble_serial_add_ctrl_if.slave  bus,
   output logic                     busy
);
   localparam int NIB = nib_count(WIDTH);
   localparam int KW  = k_width(WIDTH);
   state_t           state;
   logic [WIDTH-1:0] a_r, b_r, result;
   logic             carry, cout_r, ovf_r;
   logic [KW-1:0]    k;
   logic [3:0]       a_nib, b_nib, s_nib;
   logic             c3, c4;
   assign a_nib = a_r[k*NIBBLE +: NIBBLE];
   assign b_nib = b_r[k*NIBBLE +: NIBBLE];
   nibble_serial_add_ctrl_cla4 u_cla4 (
      .a   (a_nib),
      .b   (b_nib),
      .cin (carry),
      .sum (s_nib),
      .c3  (c3),
      .c4  (c4)
   );
   // sequencer: accept operands, ripple one nibble per cycle, hold result until taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         result <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         k      <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.in_valid) begin
               a_r   <= bus.in_a;
               b_r   <= bus.in_b ^ {WIDTH{bus.in_sub}};
               carry <= bus.in_sub;
               k     <= '0;
               state <= RUN;
            end
            RUN: begin
               result[k*NIBBLE +: NIBBLE] <= s_nib;
               carry <= c4;
               k     <= k + 1'b1;
               if (k == KW'(NIB - 1)) begin
                  cout_r <= c4;
                  ovf_r  <= c4 ^ c3;
                  state  <= DONE;
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign busy          = state != IDLE;
   assign bus.out_sum   = result;
   assign bus.out_cout  = cout_r;
   assign bus.out_ovf   = ovf_r;
endmodule
